// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the memory-bus interconnect.
// Holds FSM state encodings, bus widths and the trap instruction word.
package mem_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] ILLEGAL_INSTRUCTION = 32'h0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

endpackage

// File: rtl/mem_bus_mux_if.sv
// mem_bus_mux_if: CPU-side native port plus fanned-out slave port bundle.
// modport slave: interconnect view; modport master: CPU/slave-model view.
interface mem_bus_mux_if #(
  parameter int NUM_SLAVES = 8
);
  import mem_bus_pkg::*;

  logic                     cpu_valid;
  logic [ADDR_W-1:0]        cpu_addr;
  logic [DATA_W-1:0]        cpu_wdata;
  logic [3:0]               cpu_wstrb;
  logic                     cpu_ready;
  logic [DATA_W-1:0]        cpu_rdata;

  logic [NUM_SLAVES-1:0]    slv_cs;
  logic                     slv_we;
  logic [3:0]               slv_wstrb;
  logic [ADDR_W-1:0]        slv_addr;
  logic [DATA_W-1:0]        slv_wdata;
  logic [NUM_SLAVES*32-1:0] slv_rdata;
  logic [NUM_SLAVES-1:0]    slv_ready;

  modport slave (
    input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_ready, cpu_rdata,
    output slv_cs, slv_we, slv_wstrb, slv_addr, slv_wdata,
    input  slv_rdata, slv_ready
  );

  modport master (
    output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_ready, cpu_rdata,
    input  slv_cs, slv_we, slv_wstrb, slv_addr, slv_wdata,
    output slv_rdata, slv_ready
  );

endinterface

// File: rtl/mem_bus_decoder.sv
// mem_bus_decoder: base/mask window match with lowest-index priority.
// Ports: addr in; hit (any window matched), idx (winning slave) out.
module mem_bus_decoder
  import mem_bus_pkg::*;
#(
  parameter int                       NUM_SLAVES = 8,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {NUM_SLAVES{32'hffff_ffff}},
  parameter int                       IDX_W      = 3
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  // Scan high to low so the lowest matching index is written last.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_bus_mux.sv
// mem_bus_mux: picorv32 native port to NUM_SLAVES chip-selected cores.
// Ports: clk, reset (async, active high), force_trap, bus (slave modport:
// cpu_* request/response, slv_* fan-out), err_unmapped, err_timeout.
// Build option: MEM_BUS_MUX_TIMEOUT_EN enables the ACCESS watchdog.
module mem_bus_mux
  import mem_bus_pkg::*;
#(
  parameter int                       NUM_SLAVES     = 8,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = {NUM_SLAVES{32'hffff_ffff}},
  parameter int                       TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          force_trap,
  mem_bus_mux_if.slave  bus,
  output logic          err_unmapped,
  output logic          err_timeout
);

  // A single slave still gets a 1-bit index.
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num
    $error("NUM_SLAVES must be 1..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_SLAVES-1:0] cs_q, cs_d;
  logic                  ready_q, ready_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  we_q, we_d;
  logic                  unm_q, unm_d;
  logic                  err_unm_q, err_unm_d;

`ifdef MEM_BUS_MUX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  to_q, to_d;
  logic                  err_to_q, err_to_d;
`endif

  logic                  dec_hit;
  logic [IDX_W-1:0]      dec_idx;
  logic [DATA_W-1:0]     sel_rdata;
  logic                  sel_ready;

  mem_bus_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK),
    .IDX_W      (IDX_W)
  ) u_dec (
    .addr (bus.cpu_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  // Only the latched slave's data/ready are looked at.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_rdata = bus.slv_rdata[32*i +: 32];
        sel_ready = bus.slv_ready[i];
      end
    end
  end

  // Slave completions raise cpu_ready straight out of ACCESS; trap,
  // unmapped and watchdog aborts spend one cycle in RESPOND first.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cs_d      = cs_q;
    ready_d   = 1'b0;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    we_d      = we_q;
    unm_d     = unm_q;
    err_unm_d = 1'b0;
`ifdef MEM_BUS_MUX_TIMEOUT_EN
    cnt_d     = cnt_q;
    to_d      = to_q;
    err_to_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        cs_d = '0;
        // cpu_ready is still high in the first IDLE cycle.
        if (bus.cpu_valid && !ready_q) begin
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          wstrb_d = bus.cpu_wstrb;
          we_d    = |bus.cpu_wstrb;
          unm_d   = 1'b0;
`ifdef MEM_BUS_MUX_TIMEOUT_EN
          to_d    = 1'b0;
`endif
          if (force_trap) begin
            rdata_d = ILLEGAL_INSTRUCTION;
            state_d = RESPOND;
          end else if (dec_hit) begin
            idx_d          = dec_idx;
            cs_d[dec_idx]  = 1'b1;
`ifdef MEM_BUS_MUX_TIMEOUT_EN
            cnt_d          = '0;
`endif
            state_d        = ACCESS;
          end else begin
            rdata_d = '0;
            unm_d   = 1'b1;
            state_d = RESPOND;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          rdata_d = sel_rdata;
          cs_d    = '0;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
`ifdef MEM_BUS_MUX_TIMEOUT_EN
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rdata_d = '0;
            cs_d    = '0;
            to_d    = 1'b1;
            state_d = RESPOND;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      RESPOND: begin
        ready_d   = 1'b1;
        err_unm_d = unm_q;
`ifdef MEM_BUS_MUX_TIMEOUT_EN
        err_to_d  = to_q;
`endif
        state_d   = IDLE;
      end
      default: begin
        cs_d    = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cs_q      <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      unm_q     <= 1'b0;
      err_unm_q <= 1'b0;
`ifdef MEM_BUS_MUX_TIMEOUT_EN
      cnt_q     <= '0;
      to_q      <= 1'b0;
      err_to_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cs_q      <= cs_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      we_q      <= we_d;
      unm_q     <= unm_d;
      err_unm_q <= err_unm_d;
`ifdef MEM_BUS_MUX_TIMEOUT_EN
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      err_to_q  <= err_to_d;
`endif
    end
  end

  assign bus.cpu_ready = ready_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.slv_cs    = cs_q;
  assign bus.slv_we    = we_q;
  assign bus.slv_wstrb = wstrb_q;
  assign bus.slv_addr  = addr_q;
  assign bus.slv_wdata = wdata_q;
  assign err_unmapped  = err_unm_q;

`ifdef MEM_BUS_MUX_TIMEOUT_EN
  assign err_timeout = err_to_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_mux.sv
// tb_mem_bus_mux: scoreboard bench for mem_bus_mux with 4 slave models.
// Expected responses are queued at issue and retired on cpu_ready.
module tb_mem_bus_mux;
  import mem_bus_pkg::*;

  localparam int NS = 4;
  localparam int TO = 8;
  localparam logic [NS*32-1:0] BASES = {
    32'hC100_0000, 32'hC000_0000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASKS = {
    32'hFF00_0000, 32'hFF00_0000, 32'hC000_0000, 32'hC000_0000};

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        unm;
    logic        to;
    int          t0;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic force_trap;
  logic err_unmapped;
  logic err_timeout;

  mem_bus_mux_if #(.NUM_SLAVES(NS)) bus();

  mem_bus_mux #(
    .NUM_SLAVES     (NS),
    .SLAVE_BASE     (BASES),
    .SLAVE_MASK     (MASKS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .force_trap   (force_trap),
    .bus          (bus),
    .err_unmapped (err_unmapped),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  int n_chk = 0;
  int n_pass = 0;
  exp_t sb[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Slave models: ready rises lat_cfg cycles after cs; -1 never.
  int          lat_cfg[NS];
  logic [31:0] rd_cfg[NS];
  int          wcnt[NS];

  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (bus.slv_cs[i]) wcnt[i]++;
      else wcnt[i] = 0;
      bus.slv_ready[i] = (lat_cfg[i] >= 0) && bus.slv_cs[i] &&
                         (wcnt[i] > lat_cfg[i]);
      bus.slv_rdata[32*i +: 32] = rd_cfg[i];
    end
  end

  // Response monitor / scoreboard retire.
  always @(negedge clk) begin
    if (!reset && bus.cpu_ready) begin
      if (sb.size() == 0) begin
        check("spurious_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_rdata"}, bus.cpu_rdata, e.rdata);
        check({e.tag, "_unm"}, 32'(err_unmapped), 32'(e.unm));
        check({e.tag, "_to"}, 32'(err_timeout), 32'(e.to));
        check({e.tag, "_lat"}, 32'(ecnt - e.t0), 32'(e.lat));
      end
    end
    if (!reset && !bus.cpu_ready && (err_unmapped || err_timeout))
      check("stray_err", 32'd1, 32'd0);
  end

  task automatic start_req(string tag, logic [31:0] a, logic [31:0] wd,
                           logic [3:0] ws, logic trap, logic [31:0] er,
                           logic eu, logic et, int el);
    exp_t e;
    @(negedge clk);
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_wdata = wd;
    bus.cpu_wstrb = ws;
    force_trap    = trap;
    e.tag = tag; e.rdata = er; e.unm = eu; e.to = et;
    e.t0 = ecnt; e.lat = el;
    sb.push_back(e);
    @(negedge clk);
    force_trap = 1'b0;
  endtask

  task automatic finish_req(string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (bus.cpu_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_wait"}, 32'(seen), 32'd1);
    bus.cpu_valid = 1'b0;
    bus.cpu_wstrb = 4'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench hung");
  end

  initial begin
    bit any;
    reset = 1'b1;
    force_trap = 1'b0;
    bus.cpu_valid = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_wstrb = '0;
    lat_cfg[0] = 3;  rd_cfg[0] = 32'h0A0A_0A0A;
    lat_cfg[1] = 1;  rd_cfg[1] = 32'hDEAD_BEEF;
    lat_cfg[2] = -1; rd_cfg[2] = 32'hCCCC_0002;
    lat_cfg[3] = 0;  rd_cfg[3] = 32'h3333_3333;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.cpu_ready), 32'd0);
    check("rst_rdata", bus.cpu_rdata, 32'd0);
    check("rst_cs", 32'(bus.slv_cs), 32'd0);
    check("rst_we", 32'(bus.slv_we), 32'd0);
    check("rst_wstrb", 32'(bus.slv_wstrb), 32'd0);
    check("rst_addr", bus.slv_addr, 32'd0);
    check("rst_wdata", bus.slv_wdata, 32'd0);
    check("rst_err_u", 32'(err_unmapped), 32'd0);
    check("rst_err_t", 32'(err_timeout), 32'd0);
    reset = 1'b0;

    // Read slave 1, L=1.
    start_req("rd1", 32'h4000_0010, 32'h0, 4'b0, 1'b0,
              32'hDEAD_BEEF, 1'b0, 1'b0, 3);
    check("rd1_cs_c1", 32'(bus.slv_cs), 32'h2);
    check("rd1_we", 32'(bus.slv_we), 32'd0);
    check("rd1_addr", bus.slv_addr, 32'h4000_0010);
    @(negedge clk);
    check("rd1_cs_c2", 32'(bus.slv_cs), 32'h2);
    finish_req("rd1");

    // Write slave 3, L=0.
    start_req("wr3", 32'hC100_0004, 32'h1234_5678, 4'b0011, 1'b0,
              32'h3333_3333, 1'b0, 1'b0, 2);
    check("wr3_cs", 32'(bus.slv_cs), 32'h8);
    check("wr3_we", 32'(bus.slv_we), 32'd1);
    check("wr3_wstrb", 32'(bus.slv_wstrb), 32'h3);
    check("wr3_wdata", bus.slv_wdata, 32'h1234_5678);
    check("wr3_addr", bus.slv_addr, 32'hC100_0004);
    finish_req("wr3");

    // Unmapped.
    start_req("unm", 32'h8000_0000, 32'h0, 4'b0, 1'b0,
              32'h0, 1'b1, 1'b0, 2);
    check("unm_cs", 32'(bus.slv_cs), 32'd0);
    finish_req("unm");

    // Forced trap over a mapped address.
    start_req("trap", 32'h0000_0000, 32'h0, 4'b0, 1'b1,
              ILLEGAL_INSTRUCTION, 1'b0, 1'b0, 2);
    check("trap_cs", 32'(bus.slv_cs), 32'd0);
    finish_req("trap");

    // Back-to-back after the trap, slave 0 with L=3.
    start_req("rd0", 32'h0000_0100, 32'h0, 4'b0, 1'b0,
              32'h0A0A_0A0A, 1'b0, 1'b0, 5);
    check("rd0_cs", 32'(bus.slv_cs), 32'h1);
    finish_req("rd0");

`ifdef MEM_BUS_MUX_TIMEOUT_EN
    // Ready on the expiry cycle wins.
    lat_cfg[2] = TO - 1;
    start_req("edge", 32'hC000_0040, 32'h0, 4'b0, 1'b0,
              32'hCCCC_0002, 1'b0, 1'b0, TO + 1);
    finish_req("edge");
    lat_cfg[2] = -1;
    start_req("wdog", 32'hC000_0000, 32'h0, 4'b0, 1'b0,
              32'h0, 1'b0, 1'b1, TO + 2);
    check("wdog_cs", 32'(bus.slv_cs), 32'h4);
    finish_req("wdog");
`else
    start_req("hang", 32'hC000_0000, 32'h0, 4'b0, 1'b0,
              32'h0, 1'b0, 1'b0, 0);
    any = 1'b0;
    repeat (50) begin
      @(negedge clk);
      any |= bus.cpu_ready;
    end
    check("hang_no_ready", 32'(any), 32'd0);
    check("hang_cs", 32'(bus.slv_cs), 32'h4);
    sb.delete();
    reset = 1'b1;
    bus.cpu_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
`endif

    // Reset in cycle 3 of a slave-2 access.
    lat_cfg[2] = 20;
    start_req("rst", 32'hC000_0008, 32'h0, 4'b0, 1'b0,
              32'h0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("rst_cs_c2", 32'(bus.slv_cs), 32'h4);
    @(posedge clk);
    #2;
    check("rst_cs_c3", 32'(bus.slv_cs), 32'h4);
    reset = 1'b1;
    #1;
    check("rst_cs_async", 32'(bus.slv_cs), 32'd0);
    sb.delete();
    bus.cpu_valid = 1'b0;
    any = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any |= bus.cpu_ready;
    end
    check("rst_no_ready", 32'(any), 32'd0);
    reset = 1'b0;

    start_req("post", 32'h4000_0020, 32'h0, 4'b0, 1'b0,
              32'hDEAD_BEEF, 1'b0, 1'b0, 3);
    finish_req("post");

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
